// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer scan-out block: FSM states,
// RGB565 field positions and default raster geometry.
package fb_pkg;

  // Default active raster size.
  localparam int HSIZE_DEF = 640;
  localparam int VSIZE_DEF = 480;

  // Scan-out FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_VSYNC     = 2'd1,
    ST_WAIT_LINE = 2'd2,
    ST_LINE      = 2'd3
  } fb_state_e;

  // RGB565 field positions inside a BRAM word.
  localparam int RGB_W = 16;
  localparam int R_HI  = 15;
  localparam int R_LO  = 11;
  localparam int G_HI  = 10;
  localparam int G_LO  = 5;
  localparam int B_HI  = 4;
  localparam int B_LO  = 0;

endpackage

// File: rtl/fb_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear, used to
// keep DE and the sync strobes aligned with the BRAM read pipeline.
module fb_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift one stage per clock; reset empties every stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: turns the incoming video timing into BRAM read
// addresses (with optional vertical flip and horizontal mirror latched per
// frame) and re-times the RGB565 read data against delayed syncs.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int HSIZE  = HSIZE_DEF,
  parameter int VSIZE  = VSIZE_DEF,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Vsync,
  input  logic              Hsync,
  input  logic              DE,
  input  logic              Reverse_SW,
  input  logic              Mirror_SW,
  output logic              BRAMCLK,
  output logic [ADDR_W-1:0] BRAMADDR,
  input  logic [RGB_W-1:0]  BRAMDATA,
  output logic [4:0]        R,
  output logic [5:0]        G,
  output logic [4:0]        B,
  output logic              DE_out,
  output logic              Hsync_out,
  output logic              Vsync_out,
  output logic              overrun
);

  localparam int COL_W  = (HSIZE > 1) ? $clog2(HSIZE) : 1;
  localparam int LCNT_W = $clog2(VSIZE + 1);

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(HSIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((VSIZE - 1) * HSIZE);
  localparam logic [ADDR_W-1:0] HSTEP     = ADDR_W'(HSIZE);
  localparam logic [LCNT_W-1:0] LINES     = LCNT_W'(VSIZE);
  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(VSIZE - 1);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("fb_scanout: RD_LAT must be in 1..3");
  end
  if (longint'(HSIZE) * longint'(VSIZE) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("fb_scanout: HSIZE*VSIZE does not fit in ADDR_W");
  end

  logic [1:0]        state;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] base;
  logic [LCNT_W-1:0] line_cnt;
  logic              vflip;
  logic              mirror;

  logic [COL_W-1:0]  col_first;
  logic [COL_W-1:0]  col_last;
  logic [COL_W-1:0]  col_next;
  logic              de_act;
  logic [2:0]        align_p0;
  logic [2:0]        align_p1;

  assign BRAMCLK = CLK;

  // Column walk: start and end swap under mirror, and the walk sticks at the end.
  assign col_first = mirror ? COL_MAX : '0;
  assign col_last  = mirror ? '0 : COL_MAX;
  assign col_next  = (col == col_last) ? col
                   : (mirror ? col - COL_W'(1) : col + COL_W'(1));

  // Only DE cycles that actually produce a read address travel down the pipe.
  assign de_act = DE && Vsync && (state == ST_WAIT_LINE || state == ST_LINE);

  // Syncs are carried active-high so a cleared stage reads as inactive.
  assign align_p0 = {~Vsync, ~Hsync, de_act};

  // Address generator FSM; Vsync=0 restarts the frame from any state.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      col      <= '0;
      base     <= '0;
      line_cnt <= '0;
      vflip    <= 1'b0;
      mirror   <= 1'b0;
      overrun  <= 1'b0;
      BRAMADDR <= '0;
    end else if (!Vsync) begin
      state    <= ST_VSYNC;
      vflip    <= Reverse_SW;
      mirror   <= Mirror_SW;
      line_cnt <= '0;
      overrun  <= 1'b0;
      base     <= Reverse_SW ? LAST_BASE : '0;
    end else begin
      case (state)
        ST_VSYNC: state <= ST_WAIT_LINE;
        ST_WAIT_LINE: begin
          if (DE) begin
            state    <= ST_LINE;
            col      <= col_first;
            BRAMADDR <= base + ADDR_W'(col_first);
            // A line starting after the frame is complete reuses the last base.
            if (line_cnt == LINES) overrun <= 1'b1;
          end
        end
        ST_LINE: begin
          if (DE) begin
            col      <= col_next;
            BRAMADDR <= base + ADDR_W'(col_next);
            if (col == col_last) overrun <= 1'b1;
          end else begin
            state <= ST_WAIT_LINE;
            if (line_cnt != LINES) line_cnt <= line_cnt + LCNT_W'(1);
            // Base stops on the last line so it never leaves the frame.
            if (line_cnt < LAST_LINE) base <= vflip ? base - HSTEP : base + HSTEP;
          end
        end
        default: ;
      endcase
    end
  end

  fb_delay_line #(
    .WIDTH (3),
    .DEPTH (RD_LAT + 1)
  ) u_align (
    .clk     (CLK),
    .reset_n (RESET_N),
    .din     (align_p0),
    .dout    (align_p1)
  );

  // Output stage: register colour with its aligned DE and restore sync polarity.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      DE_out    <= 1'b0;
      Hsync_out <= 1'b1;
      Vsync_out <= 1'b1;
      R         <= '0;
      G         <= '0;
      B         <= '0;
    end else begin
      DE_out    <= align_p1[0];
      Hsync_out <= ~align_p1[1];
      Vsync_out <= ~align_p1[2];
      if (align_p1[0]) begin
        R <= BRAMDATA[R_HI:R_LO];
        G <= BRAMDATA[G_HI:G_LO];
        B <= BRAMDATA[B_HI:B_LO];
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout with an 8x4 raster and 1-cycle BRAM.
module tb_fb_scanout;

  localparam int HS = 8;
  localparam int VS = 4;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          Vsync;
  logic          Hsync;
  logic          DE;
  logic          Reverse_SW;
  logic          Mirror_SW;
  logic          BRAMCLK;
  logic [AW-1:0] BRAMADDR;
  logic [15:0]   BRAMDATA = '0;
  logic [4:0]    R;
  logic [5:0]    G;
  logic [4:0]    B;
  logic          DE_out;
  logic          Hsync_out;
  logic          Vsync_out;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int due;
    int addr;
  } exp_t;

  exp_t pq[$];
  int   hq[$];
  int   vq[$];

  fb_scanout #(
    .HSIZE  (HS),
    .VSIZE  (VS),
    .ADDR_W (AW),
    .RD_LAT (1)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .Vsync      (Vsync),
    .Hsync      (Hsync),
    .DE         (DE),
    .Reverse_SW (Reverse_SW),
    .Mirror_SW  (Mirror_SW),
    .BRAMCLK    (BRAMCLK),
    .BRAMADDR   (BRAMADDR),
    .BRAMDATA   (BRAMDATA),
    .R          (R),
    .G          (G),
    .B          (B),
    .DE_out     (DE_out),
    .Hsync_out  (Hsync_out),
    .Vsync_out  (Vsync_out),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory contents: every address holds a distinct pseudo-random RGB565 word.
  function automatic int pix(int a);
    return (a * 1237 + 4660) & 16'hFFFF;
  endfunction

  always @(posedge CLK) BRAMDATA <= 16'(pix(int'(BRAMADDR)));

  task automatic chk(string nm, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int col_of(int i, bit mir);
    int c;
    if (mir) c = (HS - 1 - i < 0) ? 0 : HS - 1 - i;
    else     c = (i > HS - 1) ? HS - 1 : i;
    return c;
  endfunction

  function automatic int base_of(int l, bit rev);
    int k;
    k = (l > VS - 1) ? VS - 1 : l;
    return rev ? (VS - 1 - k) * HS : k * HS;
  endfunction

  task automatic vsync_pulse(bit rev, bit mir);
    Reverse_SW = rev;
    Mirror_SW  = mir;
    Vsync = 1'b0; vq.push_back(cyc + 3); tick();
    vq.push_back(cyc + 3); tick();
    Vsync = 1'b1; tick(); tick();
  endtask

  task automatic do_line(int n, int base, bit mir);
    Hsync = 1'b0; hq.push_back(cyc + 3); tick();
    Hsync = 1'b1; tick();
    for (int i = 0; i < n; i++) begin
      DE = 1'b1;
      pq.push_back('{cyc + 3, base + col_of(i, mir)});
      tick();
    end
    DE = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic do_frame(bit rev, bit mir);
    vsync_pulse(rev, mir);
    for (int l = 0; l < VS; l++) do_line(HS, base_of(l, rev), mir);
  endtask

  // Monitor: pops expectations whenever the DUT presents pixels or sync pulses.
  always @(negedge CLK) begin
    exp_t e;
    int   d;
    if (mon_en) begin
      while (pq.size() > 0 && pq[0].due < cyc) begin
        e = pq.pop_front();
        chk("pixel_missing", cyc, e.due);
      end
      if (DE_out) begin
        if (pq.size() == 0) chk("unexpected_de_out", 1, 0);
        else begin
          e = pq.pop_front();
          chk("de_out_latency", cyc, e.due);
          chk("rgb", int'({R, G, B}), pix(e.addr));
        end
      end else begin
        chk("rgb_blank", int'({R, G, B}), 0);
      end
      while (hq.size() > 0 && hq[0] < cyc) begin
        d = hq.pop_front();
        chk("hsync_missing", cyc, d);
      end
      if (!Hsync_out) begin
        if (hq.size() == 0) chk("unexpected_hsync_out", 0, 1);
        else begin d = hq.pop_front(); chk("hsync_latency", cyc, d); end
      end
      while (vq.size() > 0 && vq[0] < cyc) begin
        d = vq.pop_front();
        chk("vsync_missing", cyc, d);
      end
      if (!Vsync_out) begin
        if (vq.size() == 0) chk("unexpected_vsync_out", 0, 1);
        else begin d = vq.pop_front(); chk("vsync_latency", cyc, d); end
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_de_out"},    int'(DE_out),    0);
    chk({tag, "_rgb"},       int'({R, G, B}), 0);
    chk({tag, "_bramaddr"},  int'(BRAMADDR),  0);
    chk({tag, "_overrun"},   int'(overrun),   0);
    chk({tag, "_hsync_out"}, int'(Hsync_out), 1);
    chk({tag, "_vsync_out"}, int'(Vsync_out), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; Vsync = 1'b1; Hsync = 1'b1; DE = 1'b0;
    Reverse_SW = 1'b0; Mirror_SW = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    mon_en  = 1'b1;
    tick();

    // IDLE ignores DE until the first Vsync.
    DE = 1'b1; repeat (4) tick(); DE = 1'b0; tick(); tick();
    chk("idle_bramaddr", int'(BRAMADDR), 0);

    // Plain, flipped, mirrored and combined frames.
    do_frame(1'b0, 1'b0);
    chk("normal_overrun", int'(overrun), 0);
    chk("normal_addr_hold", int'(BRAMADDR), 31);
    do_frame(1'b1, 1'b0);
    chk("flip_addr_hold", int'(BRAMADDR), 7);
    do_frame(1'b0, 1'b1);
    chk("mirror_addr_hold", int'(BRAMADDR), 24);
    do_frame(1'b1, 1'b1);
    chk("both_addr_hold", int'(BRAMADDR), 0);

    // Over-long first line saturates at the line end.
    vsync_pulse(1'b0, 1'b0);
    do_line(HS + 2, 0, 1'b0);
    chk("long_line_overrun", int'(overrun), 1);
    chk("long_line_addr", int'(BRAMADDR), 7);
    for (int l = 1; l < VS; l++) do_line(HS, base_of(l, 1'b0), 1'b0);
    vsync_pulse(1'b0, 1'b0);
    chk("vsync_clears_overrun", int'(overrun), 0);

    // A fifth line repeats the last base and flags overrun.
    for (int l = 0; l < VS; l++) do_line(HS, base_of(l, 1'b0), 1'b0);
    chk("four_lines_overrun", int'(overrun), 0);
    do_line(HS, base_of(VS, 1'b0), 1'b0);
    chk("extra_line_overrun", int'(overrun), 1);
    chk("extra_line_addr", int'(BRAMADDR), 31);

    // Reverse_SW toggled mid-frame only takes effect next frame.
    vsync_pulse(1'b0, 1'b0);
    chk("toggle_pre_overrun", int'(overrun), 0);
    do_line(HS, base_of(0, 1'b0), 1'b0);
    do_line(HS, base_of(1, 1'b0), 1'b0);
    Reverse_SW = 1'b1;
    do_line(HS, base_of(2, 1'b0), 1'b0);
    do_line(HS, base_of(3, 1'b0), 1'b0);
    chk("toggle_addr_hold", int'(BRAMADDR), 31);
    do_frame(1'b1, 1'b0);

    // Reset at line 2, pixel 3 of a frame that has already overrun.
    vsync_pulse(1'b0, 1'b0);
    do_line(HS, base_of(0, 1'b0), 1'b0);
    do_line(HS + 1, base_of(1, 1'b0), 1'b0);
    chk("pre_reset_overrun", int'(overrun), 1);
    Hsync = 1'b0; hq.push_back(cyc + 3); tick();
    Hsync = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      DE = 1'b1;
      pq.push_back('{cyc + 3, base_of(2, 1'b0) + i});
      tick();
    end
    RESET_N = 1'b0;
    while (pq.size() > 0 && pq[$].due > cyc) void'(pq.pop_back());
    while (hq.size() > 0 && hq[$] > cyc) void'(hq.pop_back());
    while (vq.size() > 0 && vq[$] > cyc) void'(vq.pop_back());
    tick();
    RESET_N = 1'b1;
    check_reset_outputs("midline_reset");
    repeat (HS) tick();
    DE = 1'b0; tick(); tick();
    chk("post_reset_idle_addr", int'(BRAMADDR), 0);
    do_frame(1'b0, 1'b0);
    chk("post_reset_frame_addr", int'(BRAMADDR), 31);

    repeat (8) tick();
    chk("pixel_queue_empty", pq.size(), 0);
    chk("hsync_queue_empty", hq.size(), 0);
    chk("vsync_queue_empty", vq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter HSIZE, default 640: active pixels per line.
REQ-002 Parameter VSIZE, default 480: active lines per frame.
REQ-003 Parameter ADDR_W, default 19: BRAM address width; HSIZE*VSIZE SHALL NOT exceed 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, legal range 1..3: BRAM read latency in cycles.
REQ-005 CLK  in  1  single clock for all logic and BRAMCLK.
REQ-006 RESET_N  in  1  synchronous, active-low reset.
REQ-007 Vsync  in  1  active-low vertical sync.
REQ-008 Hsync  in  1  active-low horizontal sync, delay-matched only.
REQ-009 DE  in  1  active-high pixel data enable.
REQ-010 Reverse_SW  in  1  vertical flip request.
REQ-011 Mirror_SW  in  1  horizontal mirror request.
REQ-012 BRAMCLK  out  1  equals CLK.
REQ-013 BRAMADDR  out  ADDR_W  registered read address.
REQ-014 BRAMDATA  in  16  RGB565 read data, valid RD_LAT cycles after BRAMADDR.
REQ-015 R  out  5, G  out  6, B  out  5  registered pixel colour.
REQ-016 DE_out, Hsync_out, Vsync_out  out  1 each  delay-aligned syncs.
REQ-017 overrun  out  1  sticky flag for a line or frame longer than configured.

Function
REQ-018 FSM states: IDLE, VSYNC, WAIT_LINE, LINE; the FSM SHALL leave IDLE only when Vsync=0 is sampled.
REQ-019 In any state, Vsync=0 SHALL move the FSM to VSYNC, latch Reverse_SW and Mirror_SW into frame mode bits, clear the line count and overrun, and load base = vflip ? (VSIZE-1)*HSIZE : 0.
REQ-020 VSYNC->WAIT_LINE when Vsync=1; WAIT_LINE->LINE on DE=1; LINE->WAIT_LINE on DE=0.
REQ-021 On the first DE=1 cycle of a line, col SHALL start at mirror ? HSIZE-1 : 0; each further DE=1 cycle SHALL step col by -1 (mirror) or +1 (normal).
REQ-022 BRAMADDR SHALL equal base+col registered one cycle after the DE=1 sample; it SHALL hold its last value while DE=0.
REQ-023 A line with more than HSIZE DE cycles SHALL saturate col at its end value (HSIZE-1 normal, 0 mirror) and set overrun.
REQ-024 On LINE->WAIT_LINE, the line count SHALL increment and base SHALL move by -HSIZE (vflip) or +HSIZE (normal), unless VSIZE lines are already complete.
REQ-025 Lines beyond VSIZE SHALL reuse the last line base and set overrun; base SHALL never wrap below 0 or above (VSIZE-1)*HSIZE.
REQ-026 Mode inputs SHALL affect only the frame after the next Vsync=0.
REQ-027 Total latency from DE to DE_out SHALL be RD_LAT+2 cycles; Hsync and Vsync SHALL be delayed identically.
REQ-028 R=BRAMDATA[15:11], G=[10:5], B=[4:0], registered, and forced to 0 when the aligned DE_out is 0.
REQ-029 In IDLE, DE SHALL be ignored; DE_out, R, G and B SHALL be 0.

Reset
REQ-030 RESET_N=0 at a CLK edge SHALL force: FSM to IDLE; BRAMADDR, col, base, line count, mode bits, overrun, R, G and B to 0; all delay stages to 0. Hsync_out and Vsync_out SHALL be forced to 1 (inactive).
REQ-031 Reset mid-line SHALL take effect on that edge, with no partial-line completion afterwards.

Structure
REQ-032 Shared package fb_pkg SHALL hold the FSM state enum, the RGB565 field constants, and the default HSIZE and VSIZE values.
REQ-033 Sub-module fb_delay_line (parameter width and depth, shift register with synchronous reset) SHALL implement the sync and DE alignment.

Verification (HSIZE=8, VSIZE=4, RD_LAT=1, 8-cycle DE per line)
REQ-034 Normal frame -> BRAMADDR runs 0..7, 8..15, 16..23, 24..31; DE_out rises 3 cycles after DE; overrun=0.
REQ-035 Reverse_SW=1 before Vsync -> lines are 24..31, 16..23, 8..15, 0..7.
REQ-036 Mirror_SW=1 -> first line is 7,6,...,0; both switches set -> first line is 31..24.
REQ-037 10-cycle DE -> addresses 0..7,7,7 and overrun=1; a 5th line repeats 24..31; the next Vsync=0 clears overrun.
REQ-038 RESET_N=0 for 1 cycle at line 2, pixel 3 -> all outputs reset next cycle; DE ignored until Vsync=0; the next frame starts at address 0.
REQ-039 Toggle Reverse_SW mid-frame -> current frame stays unchanged; the flip appears from the next frame.
